// File: rtl/rst_seq.sv
// ============================================================================
// Module   : rst_seq
// Brief    : Staged reset-release sequencer. After a guard period it releases
//            NUM_STAGES active-low domain resets in index order, STAGE_DLY
//            cycles apart, with a soft-reset request/ack to replay the sequence.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module rst_seq #(
    parameter int NUM_STAGES = 4,
    parameter int HOLD_CYC   = 8,
    parameter int STAGE_DLY  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  soft_rst_req_i,
    output logic                  soft_rst_ack_o,
    output logic [NUM_STAGES-1:0] rst_stage_no,
    output logic                  rst_done_o
);

    localparam int C_CNT_MAX = (HOLD_CYC > STAGE_DLY) ? HOLD_CYC : STAGE_DLY;
    localparam int C_CW      = $clog2(C_CNT_MAX + 1);
    localparam int C_IW      = $clog2(NUM_STAGES + 1);

    localparam logic [C_CW-1:0]       C_HOLD_LAST = C_CW'(HOLD_CYC - 1);
    localparam logic [C_CW-1:0]       C_DLY_LAST  = C_CW'(STAGE_DLY - 1);
    localparam logic [C_CW-1:0]       C_CNT_ONE   = C_CW'(1);
    localparam logic [C_IW-1:0]       C_IDX_LAST  = C_IW'(NUM_STAGES - 1);
    localparam logic [C_IW-1:0]       C_IDX_ONE   = C_IW'(1);
    localparam logic [NUM_STAGES-1:0] C_STAGE_ONE = NUM_STAGES'(1);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [C_CW-1:0]       r_cnt;
    logic [C_CW-1:0]       w_cnt_nxt;
    logic [C_IW-1:0]       r_idx;
    logic [C_IW-1:0]       w_idx_nxt;
    logic [NUM_STAGES-1:0] r_stage_n;
    logic [NUM_STAGES-1:0] w_stage_n_nxt;
    logic                  r_done;
    logic                  w_done_nxt;
    logic                  r_ack;
    logic                  w_ack_nxt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_HOLD;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_stage_n <= '0;
            r_done    <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_stage_n <= w_stage_n_nxt;
            r_done    <= w_done_nxt;
            r_ack     <= w_ack_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_stage_n_nxt = r_stage_n;
        w_done_nxt    = r_done;
        w_ack_nxt     = 1'b0;

        case (r_state)
            S_HOLD: begin
                if (r_cnt == C_HOLD_LAST) begin
                    w_state_nxt = S_RELEASE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end

            S_RELEASE: begin
                if (r_cnt == C_DLY_LAST) begin
                    // Bits are set strictly in index order, so release is monotonic.
                    w_stage_n_nxt = r_stage_n | (C_STAGE_ONE << r_idx);
                    w_cnt_nxt     = '0;
                    w_idx_nxt     = r_idx + C_IDX_ONE;
                    if (r_idx == C_IDX_LAST) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_RUN;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end

            S_RUN: begin
                if (soft_rst_req_i) begin
                    w_ack_nxt     = 1'b1;
                    w_stage_n_nxt = '0;
                    w_done_nxt    = 1'b0;
                    w_state_nxt   = S_HOLD;
                    w_cnt_nxt     = '0;
                    w_idx_nxt     = '0;
                end
            end

            default: begin
                w_state_nxt   = S_HOLD;
                w_cnt_nxt     = '0;
                w_idx_nxt     = '0;
                w_stage_n_nxt = '0;
                w_done_nxt    = 1'b0;
            end
        endcase
    end

    assign soft_rst_ack_o = r_ack;
    assign rst_stage_no   = r_stage_n;
    assign rst_done_o     = r_done;

endmodule

`default_nettype wire
